// File: rtl/clk_div_param.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_param
// Brief    : Programmable clock-enable divider. It emits a one-cycle tick every
//            N enabled cycles and a divided clock in pulse or square mode.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_param #(
  parameter int CTR_W          = 8,
  parameter int DEFAULT_DIV    = 6,
  parameter bit DEFAULT_SQUARE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [CTR_W-1:0] i_div,
  input  logic             i_div_load,
  input  logic             i_square,
  output logic             o_tick,
  output logic             o_clk,
  output logic             o_div_busy,
  output logic             o_div_err
);

  if ((DEFAULT_DIV < 1) || (DEFAULT_DIV > (2**CTR_W) - 1)) begin : g_bad_default_div
    $error("clk_div_param: DEFAULT_DIV out of range 1..2^CTR_W-1");
  end

  localparam logic [CTR_W-1:0] C_DEFAULT_DIV = CTR_W'(DEFAULT_DIV);
  localparam logic [CTR_W-1:0] C_ONE         = CTR_W'(1);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [CTR_W-1:0] div_q, div_d;
  logic [CTR_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             square_q, square_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic             err_q, err_d;

  logic [CTR_W-1:0] last_cnt;
  logic [CTR_W-1:0] high_cnt;
  logic             load_ok;

  assign last_cnt = div_q - C_ONE;
  // ceil(N/2) written so it cannot overflow at N = 2^CTR_W - 1
  assign high_cnt = div_q - (div_q >> 1);
  assign load_ok  = i_div_load && (i_div != '0);

  always_comb begin
    ctr_d      = ctr_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    square_d   = square_q;
    tick_d     = 1'b0;
    clk_d      = clk_q;
    err_d      = i_div_load && (i_div == '0);

    if (i_sync) begin
      ctr_d    = '0;
      clk_d    = 1'b0;
      square_d = i_square;
      if (pend_vld_q) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
    end else if (i_en) begin
      if (ctr_q == last_cnt) begin
        ctr_d    = '0;
        tick_d   = 1'b1;
        clk_d    = 1'b1;
        square_d = i_square;
        if (pend_vld_q) begin
          div_d      = pend_q;
          pend_vld_d = 1'b0;
        end
      end else begin
        ctr_d = ctr_q + C_ONE;
        // square output only ever falls mid-period; it rises at the boundary
        clk_d = square_q && clk_q && (ctr_d < high_cnt);
      end
    end else begin
      clk_d = square_q && clk_q;
    end

    // a load on an applying edge lands in pending for the next boundary
    if (load_ok) begin
      pend_d     = i_div;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctr_q      <= '0;
      div_q      <= C_DEFAULT_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      square_q   <= DEFAULT_SQUARE;
      tick_q     <= 1'b0;
      clk_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      square_q   <= square_d;
      tick_q     <= tick_d;
      clk_q      <= clk_d;
      err_q      <= err_d;
    end
  end

  assign o_tick     = tick_q;
  assign o_clk      = clk_q;
  assign o_div_busy = pend_vld_q;
  assign o_div_err  = err_q;

endmodule
`default_nettype wire

// File: doc/clk_div_param.md
Name: clk_div_param

Overview:
Parametrised programmable clock-enable divider, the generalised successor to the fixed 6:1 divider. Divides i_clk by a runtime-loadable ratio N and emits a one-cycle strobe (o_tick) plus a divided output (o_clk) in either pulse or ~50% square-wave mode. Divisor and mode changes are glitch-free: they take effect only at a period boundary. Used wherever slow peripheral clocks or enables are derived from the system clock (e.g. 6 MHz -> 1 MHz).

Parameters:
CTR_W, 8, width of counter and divisor; max N = 2^CTR_W - 1
DEFAULT_DIV, 6, divisor N after reset; elaboration error unless 1 <= DEFAULT_DIV <= 2^CTR_W - 1
DEFAULT_SQUARE, 0, output mode after reset (0 = pulse, 1 = square)

Ports:
i_clk  input  1  system clock; all logic on posedge
i_rst  input  1  reset, asynchronous, active-high
i_en  input  1  count enable
i_sync  input  1  synchronous restart of the current period
i_div  input  CTR_W  new divisor value
i_div_load  input  1  one-cycle strobe: load i_div into pending register
i_square  input  1  requested mode (0 pulse, 1 square); sampled at period boundary
o_tick  output  1  one-cycle strobe, once per N enabled cycles
o_clk  output  1  divided clock output
o_div_busy  output  1  pending divisor/mode not yet applied
o_div_err  output  1  one-cycle pulse: rejected load (i_div == 0)

Behaviour:
- Reset (async assert, sync-released use): ctr=0, div=DEFAULT_DIV, mode=DEFAULT_SQUARE, pending cleared; o_tick=0, o_clk=0, o_div_busy=0, o_div_err=0.
- Enabled edge = posedge with i_en=1, i_sync=0, not in reset.
- Counter: ctr increments on each enabled edge; on the edge where ctr == div-1 it wraps to 0 and that edge is a "boundary".
- o_tick: registered; 1 for the cycle after each boundary edge, else 0. First tick after reset release = after the N-th enabled edge. N=1: o_tick high every enabled cycle.
- o_clk, pulse mode: identical to o_tick.
- o_clk, square mode: rises with o_tick; high ceil(N/2) enabled cycles, low floor(N/2). N=6: 3/3. N=5: 3/2. N=1: constant 1 while enabled.
- i_en=0: ctr, o_clk, div frozen; o_tick=0 next cycle. No phase loss on resume.
- i_div_load with i_div != 0: pending <= i_div, o_div_busy=1 from next cycle. Load while busy overwrites pending (last wins).
- i_div_load with i_div == 0: ignored, pending unchanged; o_div_err=1 for exactly one cycle.
- Apply: at a boundary edge, if pending valid then div <= pending, busy clears next cycle; mode <= i_square at every boundary. Load on the same edge as a boundary goes to pending and applies at the following boundary.
- i_sync=1 (priority over i_en): ctr <= 0, o_tick <= 0, o_clk <= 0, pending divisor (if any) applied immediately, mode <= i_square. Next tick after N enabled edges. Load coincident with sync: goes to pending, not applied by that sync.
- i_rst mid-period: all state to reset values immediately (async); pending load discarded.
- Arithmetic: all comparisons CTR_W wide; ceil(N/2) computed as N - (N>>1), no overflow at N = 2^CTR_W - 1.

Test Plan:
- Reset release, i_en=1, defaults (N=6, pulse) -> o_tick high 1 cycle every 6 cycles, first after 6th edge; o_clk == o_tick.
- i_square=1, load i_div=5 mid-period -> o_div_busy=1 until boundary; current period completes at 6, then o_clk high 3 / low 2 repeating, o_tick every 5.
- Load i_div=0 -> o_div_err pulses 1 cycle, divisor stays 6, busy stays 0.
- i_en low for 4 cycles at ctr=3 -> o_tick stays 0, o_clk holds; next tick lands exactly 3 enabled edges after resume (6 total enabled).
- Load 9 then 4 before boundary, then i_sync -> N=4 applied immediately, first tick 4 edges after sync; N=1 and N=255 (CTR_W=8) both tick correctly.
- Assert i_rst asynchronously mid-period (between clock edges) -> all outputs 0 immediately, pending discarded, restart at N=DEFAULT_DIV.
